i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C target (slave) attached to the two-wire bus through the `dut` modport of the I2C interface. Open-drain sda/scl; bus pull-ups resolve released lines to 1.
- Holds a small byte-addressed register file. A bus controller writes it through a register pointer and reads it back with auto-increment.
- All logic runs on system_clock. sda/scl are oversampled and are not used as clocks.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit bus address the block answers to.
- NUM_REGS, 16, register file depth in bytes; a power of two, at least 2.
- SYNC_STAGES, 2, synchronizer flops on sampled sda/scl.

Ports:
- system_clock  input  1  sole clock; must be at least 10x the scl frequency.
- reset  input  1  asynchronous, active-high reset.
- sda  inout  1  serial data, open-drain: the block drives only 1'b0 or 1'bz, never 1'b1.
- scl  inout  1  serial clock; the block always releases it (1'bz), with no clock stretching.

Behaviour:
- Sampling:
  - sda and scl each pass through SYNC_STAGES flops. A z or x sample is treated as 1.
  - Edges are detected on the synchronized copies, comparing current against previous sample.
- Bus conditions:
  - START: synchronized sda falls while scl is high.
  - STOP: synchronized sda rises while scl is high.
  - Either condition is honoured in every state. START, including a repeated START, goes to ADDR with the bit counter cleared. STOP goes to IDLE and releases sda.
- Data timing:
  - Bits are sampled on the synchronized scl rising edge.
  - The block updates its sda drive one system_clock after the synchronized scl falling edge, which gives hold time.
  - sda never changes while scl is high, except on release at STOP or reset.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits, MSB first. If bits[7:1] equal TARGET_ADDR, go to ADDR_ACK. Otherwise go to IGNORE, which releases sda and waits for START or STOP.
  - ADDR_ACK: drive sda=0 for the ninth clock. The R/W bit then selects the next state: 0 → PTR, 1 → READ, with the shift register loaded from regs[ptr].
  - PTR: shift in 8 bits. ptr is set to byte modulo NUM_REGS. Then PTR_ACK (drive 0), then WRITE.
  - WRITE: shift in 8 bits, write regs[ptr], ptr increments. Then WRITE_ACK (drive 0), then WRITE again.
  - READ: shift out 8 bits MSB first. Each bit drives sda=0 for a 0 and z for a 1. Then sda is released for the ninth clock and the master ACK is sampled.
    - ACK (0): ptr increments, reload the shift register, back to READ.
    - NACK (1): go to IGNORE until STOP or START.
- Pointer wrap: ptr increments modulo NUM_REGS, so NUM_REGS-1 wraps to 0.
- A write transfer that ends after PTR with a repeated START sets the read start address (the standard combined format).
- The ACK drive is released on the falling scl edge after the ninth clock.
- Reset (asynchronous, any time, including mid-byte):
  - State goes to IDLE and the bit counter clears.
  - ptr=0 and all registers are 0.
  - sda and scl are released (z).
  - The block remains released until the next START after reset deasserts.
- Bus errors: a START or STOP in the middle of a byte aborts that byte. The partial byte is not written and ptr is unchanged.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE);
  - constants I2C_WRITE=0 and I2C_READ=1.
- Sub-module i2c_line_sync: synchronizer and edge/START/STOP detector for sda/scl, outputs scl_rise, scl_fall, start_det, stop_det, sda_s.
- Top level holds the FSM, shift register, bit counter, pointer and register file.

Test Plan:
- Address 0x50, write: START, 0xA0, ptr 0x03, data 0x5A, 0xC3, STOP → ACK low on all four ninth clocks; regs[3]=0x5A, regs[4]=0xC3.
- Combined read: START 0xA0, ptr 0x03, repeated START 0xA1, read 2 bytes (master ACK, then NACK), STOP → returns 0x5A then 0xC3; sda released after the NACK.
- Wrong address 0x51 (byte 0xA2) → sda stays z on the ninth clock; regs unchanged; next START 0xA0 is acknowledged normally.
- Wrap: write ptr 0x0F, data 0x11, 0x22 → regs[15]=0x11, regs[0]=0x22.
- Reset asserted mid-byte during READ → sda released immediately; a subsequent read of ptr 0 returns 0x00.
- Open-drain check over all scenarios → sda and scl are never driven to 1 or x by the DUT; scl is always z.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bus constants for the I2C target
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        IGNORE
    } state_e;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_if.sv
// rtl/i2c_if.sv - two-wire open-drain bus with pull-ups on both lines
interface i2c_if;

    wire sda;
    wire scl;

    pullup pu_sda (sda);
    pullup pu_scl (scl);

    modport dut  (inout sda, inout scl);
    modport host (inout sda, inout scl);

endinterface

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - synchronizes sda/scl and flags scl edges, START and STOP
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sda_i,
    input  logic scl_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic                   sda_prev_q;
    logic                   scl_prev_q;
    logic                   scl_s;
    logic                   sda_in;
    logic                   scl_in;

    // Anything other than a solid 0 (released, unknown) reads as the pulled-up level.
    assign sda_in = (sda_i === 1'b0) ? 1'b0 : 1'b1;
    assign scl_in = (scl_i === 1'b0) ? 1'b0 : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sda_sync_q <= '1;
            scl_sync_q <= '1;
            sda_prev_q <= 1'b1;
            scl_prev_q <= 1'b1;
        end else begin
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_prev_q <= sda_s;
            scl_prev_q <= scl_s;
        end
    end

    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - oversampled I2C target with a pointer-addressed byte register file
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2
) (
    input logic system_clock,
    input logic reset,
    i2c_if.dut  bus
);

    localparam int PW = $clog2(NUM_REGS);

    state_e          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            sda_low_q, sda_low_d;
    logic            fall_d1_q;
    logic [7:0]      regs_q [NUM_REGS];
    logic            wr_en;
    logic [7:0]      byte_in;
    logic [PW-1:0]   ptr_inc;

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (system_clock),
        .rst       (reset),
        .sda_i     (bus.sda),
        .scl_i     (bus.scl),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign bus.sda = sda_low_q ? 1'b0 : 1'bz;
    assign bus.scl = 1'bz;

    assign byte_in = {shift_q[6:0], sda_s};
    assign ptr_inc = ptr_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_low_d = sda_low_q;
        wr_en     = 1'b0;
        if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                ADDR, PTR, WRITE: begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == ADDR) begin
                            state_d = (byte_in[7:1] == TARGET_ADDR) ? ADDR_ACK : IGNORE;
                        end else if (state_q == PTR) begin
                            ptr_d   = byte_in[PW-1:0];
                            state_d = PTR_ACK;
                        end else begin
                            wr_en   = 1'b1;
                            ptr_d   = ptr_inc;
                            state_d = WRITE_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (shift_q[0] == I2C_READ) begin
                        state_d = READ;
                        shift_d = regs_q[ptr_q];
                    end else begin
                        state_d = PTR;
                    end
                end
                PTR_ACK, WRITE_ACK: state_d = WRITE;
                READ: begin
                    // The bit just clocked out stays on sda until the next falling edge.
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = READ_ACK;
                end
                READ_ACK: begin
                    if (!sda_s) begin
                        ptr_d   = ptr_inc;
                        shift_d = regs_q[ptr_inc];
                        state_d = READ;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                default: ;
            endcase
        end else if (fall_d1_q) begin
            case (state_q)
                ADDR_ACK, PTR_ACK, WRITE_ACK: sda_low_d = 1'b1;
                READ:                         sda_low_d = ~shift_q[7];
                default:                      sda_low_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_low_q <= 1'b0;
            fall_d1_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_low_q <= sda_low_d;
            fall_d1_q <= scl_fall;
            if (wr_en) regs_q[ptr_q] <= byte_in;
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - bit-banged bus host with a transaction-level register model
module tb_i2c_target;

    localparam int         Q     = 8;
    localparam int         NREGS = 16;
    localparam logic [6:0] TADDR = 7'h50;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_if bus ();

    logic host_sda_low;
    logic host_scl_low;
    assign bus.sda = host_sda_low ? 1'b0 : 1'bz;
    assign bus.scl = host_scl_low ? 1'b0 : 1'bz;

    i2c_target #(.TARGET_ADDR(TADDR), .NUM_REGS(NREGS), .SYNC_STAGES(2)) dut (
        .system_clock (clk),
        .reset        (rst),
        .bus          (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic       chk_en = 1'b0;
    logic       exp_sda = 1'b1;
    int         lit_req = 0;
    int         lit_seen = 0;
    logic [7:0] lit_got, lit_exp;
    string      lit_name;

    logic [7:0] m_regs [NREGS];
    int         m_ptr;
    logic [7:0] wdata [8];
    logic [7:0] rdata [8];

    // Single compare process: per-cycle bus checks plus queued literal checks.
    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (bus.scl !== !host_scl_low) begin
                errors++;
                $display("FAIL scl_released: bus scl=%b required %b at %0t", bus.scl, !host_scl_low, $time);
            end
            if (chk_en) begin
                checks++;
                if (bus.sda !== exp_sda) begin
                    errors++;
                    $display("FAIL sda_bit: bus sda=%b required %b at %0t", bus.sda, exp_sda, $time);
                end
            end
            if (lit_req != lit_seen) begin
                lit_seen = lit_req;
                checks++;
                if (lit_got !== lit_exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%02h required 0x%02h", lit_name, lit_got, lit_exp);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        lit_name = name;
        lit_got  = got;
        lit_exp  = exp;
        lit_req++;
        @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input logic drive_val, input logic expect_val, output logic seen);
        host_sda_low = ~drive_val;
        wait_clks(Q);
        exp_sda      = expect_val;
        host_scl_low = 1'b0;
        wait_clks(2);
        chk_en = 1'b1;
        wait_clks(Q - 2);
        seen = bus.sda;
        wait_clks(Q);
        chk_en       = 1'b0;
        host_scl_low = 1'b1;
        wait_clks(Q);
    endtask

    task automatic i2c_start();
        host_sda_low = 1'b0;
        wait_clks(Q);
        host_scl_low = 1'b0;
        wait_clks(Q);
        host_sda_low = 1'b1;
        wait_clks(Q);
        host_scl_low = 1'b1;
        wait_clks(Q);
    endtask

    task automatic i2c_stop();
        host_sda_low = 1'b1;
        wait_clks(Q);
        host_scl_low = 1'b0;
        wait_clks(Q);
        host_sda_low = 1'b0;
        wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic acked);
        logic seen;
        for (int i = 7; i >= 0; i--) send_bit(b[i], b[i], seen);
        send_bit(1'b1, !acked, seen);
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic master_ack, output logic [7:0] got);
        logic seen;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, exp[i], seen);
            got[i] = seen;
        end
        send_bit(!master_ack, !master_ack, seen);
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [7:0] p, input int n, input logic do_stop);
        logic hit;
        hit = (addr == TADDR);
        i2c_start();
        write_byte({addr, 1'b0}, hit);
        write_byte(p, hit);
        if (hit) m_ptr = p % NREGS;
        for (int k = 0; k < n; k++) begin
            write_byte(wdata[k], hit);
            if (hit) begin
                m_regs[m_ptr] = wdata[k];
                m_ptr = (m_ptr + 1) % NREGS;
            end
        end
        if (do_stop) i2c_stop();
    endtask

    task automatic do_read(input int n);
        logic [7:0] got;
        logic       last;
        i2c_start();
        write_byte({TADDR, 1'b1}, 1'b1);
        for (int k = 0; k < n; k++) begin
            last = (k == n - 1);
            read_byte(m_regs[m_ptr], !last, got);
            rdata[k] = got;
            check8("read_data", got, m_regs[m_ptr]);
            if (!last) m_ptr = (m_ptr + 1) % NREGS;
        end
        check8("sda_released_after_nack", {7'd0, bus.sda}, 8'h01);
        i2c_stop();
    endtask

    initial begin
        host_sda_low = 1'b0;
        host_scl_low = 1'b0;
        rst          = 1'b1;
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        wait_clks(4);
        check8("reset_sda", {7'd0, bus.sda}, 8'h01);
        check8("reset_scl", {7'd0, bus.scl}, 8'h01);
        rst = 1'b0;
        wait_clks(4 * Q);

        wdata[0] = 8'h5A;
        wdata[1] = 8'hC3;
        do_write(TADDR, 8'h03, 2, 1'b1);
        check8("model_reg3", m_regs[3], 8'h5A);

        do_write(TADDR, 8'h03, 0, 1'b0);
        do_read(2);
        check8("combined_read0", rdata[0], 8'h5A);
        check8("combined_read1", rdata[1], 8'hC3);

        wdata[0] = 8'hFF;
        do_write(7'h51, 8'h03, 1, 1'b1);
        do_write(TADDR, 8'h03, 0, 1'b0);
        do_read(1);
        check8("wrong_addr_untouched", rdata[0], 8'h5A);

        wdata[0] = 8'h11;
        wdata[1] = 8'h22;
        do_write(TADDR, 8'h0F, 2, 1'b1);
        check8("model_wrap_reg0", m_regs[0], 8'h22);
        do_write(TADDR, 8'h0F, 0, 1'b0);
        do_read(2);
        check8("wrap_read15", rdata[0], 8'h11);
        check8("wrap_read0", rdata[1], 8'h22);

        // Reset while the target is driving the first (0) bit of 0x5A.
        do_write(TADDR, 8'h03, 0, 1'b0);
        i2c_start();
        write_byte({TADDR, 1'b1}, 1'b1);
        host_sda_low = 1'b0;
        wait_clks(Q);
        host_scl_low = 1'b0;
        wait_clks(Q);
        check8("read_bit_before_reset", {7'd0, bus.sda}, 8'h00);
        rst = 1'b1;
        #1;
        check8("sda_released_on_reset", {7'd0, bus.sda}, 8'h01);
        wait_clks(Q);
        host_scl_low = 1'b1;
        wait_clks(Q);
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        wait_clks(Q);
        i2c_stop();
        do_write(TADDR, 8'h00, 0, 1'b0);
        do_read(1);
        check8("read_after_reset", rdata[0], 8'h00);

        for (int t = 0; t < 14; t++) begin
            int         op;
            int         n;
            logic [6:0] a;
            logic [7:0] p;
            op = $urandom_range(0, 3);
            n  = $urandom_range(1, 3);
            p  = 8'($urandom_range(0, 255));
            for (int k = 0; k < 8; k++) wdata[k] = 8'($urandom_range(0, 255));
            case (op)
                0: do_write(TADDR, p, n, 1'b1);
                1: begin
                    do_write(TADDR, p, 0, 1'b0);
                    do_read(n);
                end
                2: begin
                    a = 7'($urandom_range(0, 127));
                    if (a == TADDR) a = a + 7'd1;
                    do_write(a, p, n, 1'b1);
                end
                default: do_read(n);
            endcase
        end

        wait_clks(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
